// File: rtl/ahb_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_if
//
// AHB-side front end of the AHB-to-APB bridge. It qualifies AHB transfers,
// decodes the address into a one-hot APB slave select and pipelines the
// address, write data and direction into the two-deep registers that the
// APB controller consumes. Unmapped but active transfers get a two-cycle
// AHB ERROR response. APB read data is passed straight back to the AHB bus.
//
// Ports:
//   Hclk        in   bridge clock, rising edge
//   Hreset      in   synchronous active-high reset
//   Hwrite      in   AHB direction (1 = write)
//   Hreadyin    in   AHB HREADY; address phases are accepted only when 1
//   Htrans      in   AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   Haddr       in   AHB address (decode uses bits [31:26], ADDR_W >= 32)
//   Hwdata      in   AHB write data
//   Prdata      in   APB read data from the selected peripheral
//   valid       out  combinational: qualified, mapped transfer this cycle
//   tempselx    out  combinational one-hot slave select
//   Haddr1/2    out  address pipeline stages 1 and 2
//   Hwdata1/2   out  write-data pipeline stages 1 and 2
//   Hwritereg   out  Hwrite registered with the accepted address phase
//   Hrdata      out  combinational copy of Prdata
//   Hresp       out  registered response (0 OKAY, 1 ERROR)
//   Hready_err  out  registered; 0 stalls the bus in the first ERROR cycle
// ---------------------------------------------------------------------------
module ahb_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              valid,
    output logic [2:0]        tempselx,
    output logic [ADDR_W-1:0] Haddr1,
    output logic [ADDR_W-1:0] Haddr2,
    output logic [DATA_W-1:0] Hwdata1,
    output logic [DATA_W-1:0] Hwdata2,
    output logic              Hwritereg,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hresp,
    output logic              Hready_err
);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_ERR1 = 2'd1,
        E_ERR2 = 2'd2
    } err_state_e;

    err_state_e        err_state_q;
    logic              hresp_q;
    logic              hready_err_q;
    logic [ADDR_W-1:0] haddr1_q, haddr2_q;
    logic [DATA_W-1:0] hwdata1_q, hwdata2_q;
    logic              hwrite_q;

    logic              active;
    logic              unmapped;

    // Address decode: three 64 MB windows starting at 0x8000_0000.
    always_comb begin
        tempselx = 3'b000;
        case (Haddr[31:26])
            6'b100000: tempselx = 3'b001;
            6'b100001: tempselx = 3'b010;
            6'b100010: tempselx = 3'b100;
            default:   tempselx = 3'b000;
        endcase
    end

    // Only NONSEQ/SEQ with HREADY high are real address phases.
    assign active   = Hreadyin & Htrans[1];
    assign unmapped = (tempselx == 3'b000);

    // A mapped transfer offered while the ERROR response is running is
    // ignored; the master must re-issue it.
    assign valid  = active & ~unmapped & (err_state_q == E_IDLE);
    assign Hrdata = Prdata;

    // Address / data / direction pipeline; frozen while HREADY is low.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite_q  <= 1'b0;
        end else if (Hreadyin) begin
            haddr1_q  <= Haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= Hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite_q  <= Hwrite;
        end
    end

    // Error FSM with registered outputs. The ERROR sequence is self-timed
    // and does not wait for HREADY; a new unmapped transfer can only start
    // a fresh sequence once back in E_IDLE.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            err_state_q  <= E_IDLE;
            hresp_q      <= 1'b0;
            hready_err_q <= 1'b1;
        end else begin
            case (err_state_q)
                E_IDLE: begin
                    if (active && unmapped) begin
                        err_state_q  <= E_ERR1;
                        hresp_q      <= 1'b1;
                        hready_err_q <= 1'b0;
                    end else begin
                        hresp_q      <= 1'b0;
                        hready_err_q <= 1'b1;
                    end
                end
                E_ERR1: begin
                    err_state_q  <= E_ERR2;
                    hresp_q      <= 1'b1;
                    hready_err_q <= 1'b1;
                end
                E_ERR2: begin
                    err_state_q  <= E_IDLE;
                    hresp_q      <= 1'b0;
                    hready_err_q <= 1'b1;
                end
                default: begin
                    err_state_q  <= E_IDLE;
                    hresp_q      <= 1'b0;
                    hready_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign Haddr1     = haddr1_q;
    assign Haddr2     = haddr2_q;
    assign Hwdata1    = hwdata1_q;
    assign Hwdata2    = hwdata2_q;
    assign Hwritereg  = hwrite_q;
    assign Hresp      = hresp_q;
    assign Hready_err = hready_err_q;

endmodule
